// File: rtl/steak_timer.sv
// steak_timer: timing source for the per-steak doneness controller.
//
// Produces a one-cycle game-second strobe from a clk prescaler. It also drives a
// "show" level, which is raised after a spawn delay, and a slow "cook_phase" level.
// Each toggle of cook_phase advances the steak's doneness by one stage.
//
// Ports:
//   clk          system clock
//   resetn       synchronous, active-low reset
//   clock_en     high while the steak is actively cooking
//   show_hold_n  low = no steak (spawn delay runs), high = steak present
//   show_time    spawn delay in seconds (0..7), latched when show_hold_n falls
//   pause        (only with STEAK_TIMER_PAUSE_EN) freezes all timing
//   show         high once the spawn delay has elapsed, until show_hold_n rises
//   cook_phase   toggles every COOK_SECS seconds while clock_en is high
//   sec_pulse    one-clk strobe per game second
//
// Optional feature: define STEAK_TIMER_PAUSE_EN to add the pause input.

module steak_timer #(
  parameter int unsigned TICKS_PER_SEC  = 50000000,
  parameter int unsigned COOK_SECS      = 2,
  parameter int unsigned SHOW_BASE_SECS = 1
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       clock_en,
  input  logic       show_hold_n,
  input  logic [2:0] show_time,
`ifdef STEAK_TIMER_PAUSE_EN
  input  logic       pause,
`endif
  output logic       show,
  output logic       cook_phase,
  output logic       sec_pulse
);

  localparam int unsigned PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam int unsigned SW = (COOK_SECS > 0) ? $clog2(COOK_SECS + 1) : 1;

  localparam logic [PW-1:0] PresMax  = PW'(TICKS_PER_SEC - 1);
  localparam logic [SW-1:0] StageMax = SW'(COOK_SECS - 1);
  localparam logic [3:0]    ShowBase = 4'(SHOW_BASE_SECS);

  logic [PW-1:0] prescaler_q, prescaler_d;
  logic [3:0]    sec_cnt_q, sec_cnt_d;
  logic [3:0]    target_q, target_d;
  logic [SW-1:0] stage_cnt_q, stage_cnt_d;
  logic          show_q, show_d;
  logic          phase_q, phase_d;
  logic          hold_q, en_q;

  logic pause_w;
  logic hold_fall, en_rise, reload, pres_wrap, tick;

`ifdef STEAK_TIMER_PAUSE_EN
  assign pause_w = pause;
`else
  assign pause_w = 1'b0;
`endif

  // Edge detection and the shared prescaler-reload decision.
  always_comb begin
    hold_fall = hold_q & ~show_hold_n;   // steak removed
    en_rise   = clock_en & ~en_q;        // cooking starts
    reload    = hold_fall | en_rise;
    pres_wrap = (prescaler_q == PresMax);
    sec_pulse = pres_wrap & ~pause_w;
    // A reload restarts the second, so a coincident strobe must not count.
    tick      = sec_pulse & ~reload;
  end

  // Prescaler next state.
  always_comb begin
    prescaler_d = prescaler_q;
    if (reload) begin
      prescaler_d = '0;
    end else if (!pause_w) begin
      if (pres_wrap) begin
        prescaler_d = '0;
      end else begin
        prescaler_d = prescaler_q + PW'(1);
      end
    end
  end

  // Spawn delay: counts seconds up to the latched target, then raises show.
  always_comb begin
    sec_cnt_d = sec_cnt_q;
    target_d  = target_q;
    show_d    = show_q;
    if (show_hold_n) begin
      // Steak present: nothing to time; show drops one clk after the rise.
      sec_cnt_d = '0;
      show_d    = 1'b0;
    end else if (hold_fall) begin
      // Target is latched only here, so later show_time changes are ignored.
      target_d  = {1'b0, show_time} + ShowBase;
      sec_cnt_d = '0;
      show_d    = 1'b0;
    end else if (tick && (sec_cnt_q < target_q)) begin
      sec_cnt_d = sec_cnt_q + 4'd1;
      if ((sec_cnt_q + 4'd1) == target_q) begin
        show_d = 1'b1;
      end
    end
  end

  // Cook phase: toggles once per COOK_SECS seconds of active cooking.
  always_comb begin
    stage_cnt_d = stage_cnt_q;
    phase_d     = phase_q;
    if (!clock_en) begin
      // Wait/absent states clear the phase, so every cook starts from 0.
      stage_cnt_d = '0;
      phase_d     = 1'b0;
    end else if (tick) begin
      if (stage_cnt_q == StageMax) begin
        stage_cnt_d = '0;
        phase_d     = ~phase_q;
      end else begin
        stage_cnt_d = stage_cnt_q + SW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      prescaler_q <= '0;
      sec_cnt_q   <= '0;
      target_q    <= ShowBase;
      stage_cnt_q <= '0;
      show_q      <= 1'b0;
      phase_q     <= 1'b0;
      hold_q      <= 1'b0;
      en_q        <= 1'b0;
    end else begin
      prescaler_q <= prescaler_d;
      sec_cnt_q   <= sec_cnt_d;
      target_q    <= target_d;
      stage_cnt_q <= stage_cnt_d;
      show_q      <= show_d;
      phase_q     <= phase_d;
      // Edge detectors keep sampling even while paused.
      hold_q      <= show_hold_n;
      en_q        <= clock_en;
    end
  end

  assign show       = show_q;
  assign cook_phase = phase_q;

endmodule

// File: tb/tb_steak_timer.sv
// Self-checking bench for steak_timer (TICKS_PER_SEC=4, COOK_SECS=2, SHOW_BASE_SECS=1).
// Each scenario pushes the expected output state for an edge onto a scoreboard queue,
// advances one clock, then pops the entry and compares it with the sampled outputs.

module tb_steak_timer;

  localparam int unsigned Ticks = 4;
  localparam int unsigned Cook  = 2;
  localparam int unsigned Base  = 1;

  // Mask bits: [0] show, [1] cook_phase, [2] sec_pulse
  localparam logic [2:0] MShow  = 3'b001;
  localparam logic [2:0] MPhase = 3'b010;
  localparam logic [2:0] MPulse = 3'b100;

  logic       clk = 1'b0;
  logic       resetn;
  logic       clock_en;
  logic       show_hold_n;
  logic [2:0] show_time;
`ifdef STEAK_TIMER_PAUSE_EN
  logic       pause;
`endif
  logic       show;
  logic       cook_phase;
  logic       sec_pulse;

  always #5 clk = ~clk;

  steak_timer #(
    .TICKS_PER_SEC (Ticks),
    .COOK_SECS     (Cook),
    .SHOW_BASE_SECS(Base)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .clock_en   (clock_en),
    .show_hold_n(show_hold_n),
    .show_time  (show_time),
`ifdef STEAK_TIMER_PAUSE_EN
    .pause      (pause),
`endif
    .show       (show),
    .cook_phase (cook_phase),
    .sec_pulse  (sec_pulse)
  );

  typedef struct {
    string      tag;
    logic [2:0] mask;
    logic [2:0] val;
  } exp_t;

  exp_t        exp_q[$];
  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  // Advance to just after the next active edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    exp_t e;
    logic [2:0] obs;
    resetn = 1'b0;
    for (int k = 0; k < 3; k++) begin
      clock_en    = 1'($urandom);
      show_hold_n = 1'($urandom);
      show_time   = 3'($urandom);
      exp_q.push_back('{$sformatf("reset k=%0d", k), 3'b111, 3'b000});
      step();
      e = exp_q.pop_front();
      obs = {sec_pulse, cook_phase, show};
      n_vec++;
      if ((obs & e.mask) !== (e.val & e.mask)) begin
        n_err++;
        $display("FAIL %s: got %b want %b", e.tag, obs & e.mask, e.val & e.mask);
      end
    end
    resetn      = 1'b1;
    show_hold_n = 1'b1;
    clock_en    = 1'b0;
    show_time   = 3'd0;
    for (int k = 1; k <= 12; k++) begin
      exp_q.push_back('{$sformatf("reset_release k=%0d", k), 3'b111,
                        {((k % 4) == 3), 1'b0, 1'b0}});
      step();
      e = exp_q.pop_front();
      obs = {sec_pulse, cook_phase, show};
      n_vec++;
      if ((obs & e.mask) !== (e.val & e.mask)) begin
        n_err++;
        $display("FAIL %s: got %b want %b", e.tag, obs & e.mask, e.val & e.mask);
      end
    end
  endtask

  task automatic test_spawn();
    exp_t e;
    logic [2:0] obs;
    for (int k = -2; k <= 32; k++) begin
      if (k < 0) begin
        show_hold_n = 1'b1;
        clock_en    = 1'b0;
        exp_q.push_back('{$sformatf("spawn_idle k=%0d", k), MShow | MPhase, 3'b000});
      end else begin
        show_hold_n = 1'b0;
        show_time   = (k == 0) ? 3'd2 : 3'($urandom);
        exp_q.push_back('{$sformatf("spawn k=%0d", k), MShow | MPulse,
                          {((k % 4) == 3), 1'b0, (k >= 12)}});
      end
      step();
      e = exp_q.pop_front();
      obs = {sec_pulse, cook_phase, show};
      n_vec++;
      if ((obs & e.mask) !== (e.val & e.mask)) begin
        n_err++;
        $display("FAIL %s: got %b want %b", e.tag, obs & e.mask, e.val & e.mask);
      end
    end
  endtask

  task automatic test_cancel();
    exp_t e;
    logic [2:0] obs;
    for (int k = -2; k <= 30; k++) begin
      clock_en = 1'b0;
      if (k < 0) begin
        show_hold_n = 1'b1;
      end else if (k < 10) begin
        show_hold_n = 1'b0;
        show_time   = (k == 0) ? 3'd7 : 3'($urandom);
      end else if (k < 20) begin
        show_hold_n = 1'b1;
        show_time   = 3'($urandom);
      end else begin
        show_hold_n = 1'b0;
        show_time   = (k == 20) ? 3'd0 : 3'($urandom);
      end
      exp_q.push_back('{$sformatf("cancel k=%0d", k), MShow, {2'b00, (k >= 24)}});
      step();
      e = exp_q.pop_front();
      obs = {sec_pulse, cook_phase, show};
      n_vec++;
      if ((obs & e.mask) !== (e.val & e.mask)) begin
        n_err++;
        $display("FAIL %s: got %b want %b", e.tag, obs & e.mask, e.val & e.mask);
      end
    end
  endtask

  task automatic test_cook();
    exp_t e;
    logic [2:0] obs;
    logic ph;
    for (int k = -2; k <= 26; k++) begin
      show_hold_n = 1'b1;
      clock_en    = (k >= 0);
      ph = ((k >= 8) && (k < 16)) || (k >= 24);
      if (k < 0) begin
        exp_q.push_back('{$sformatf("cook_idle k=%0d", k), MPhase, 3'b000});
      end else begin
        exp_q.push_back('{$sformatf("cook k=%0d", k), MPhase | MPulse,
                          {((k % 4) == 3), ph, 1'b0}});
      end
      step();
      e = exp_q.pop_front();
      obs = {sec_pulse, cook_phase, show};
      n_vec++;
      if ((obs & e.mask) !== (e.val & e.mask)) begin
        n_err++;
        $display("FAIL %s: got %b want %b", e.tag, obs & e.mask, e.val & e.mask);
      end
    end
  endtask

  task automatic test_wait();
    exp_t e;
    logic [2:0] obs;
    logic ph;
    for (int k = -2; k <= 24; k++) begin
      show_hold_n = 1'b1;
      clock_en    = (k >= 0) && !((k >= 10) && (k <= 12));
      ph = (k == 8) || (k == 9) || (k >= 21);
      exp_q.push_back('{$sformatf("wait k=%0d", k), MPhase, {1'b0, ph, 1'b0}});
      step();
      e = exp_q.pop_front();
      obs = {sec_pulse, cook_phase, show};
      n_vec++;
      if ((obs & e.mask) !== (e.val & e.mask)) begin
        n_err++;
        $display("FAIL %s: got %b want %b", e.tag, obs & e.mask, e.val & e.mask);
      end
    end
  endtask

  // Steak removed and cooking enabled on the same edge: one shared reload.
  task automatic test_back_to_back();
    exp_t e;
    logic [2:0] obs;
    for (int k = -2; k <= 12; k++) begin
      if (k < 0) begin
        show_hold_n = 1'b1;
        clock_en    = 1'b0;
        exp_q.push_back('{$sformatf("b2b_idle k=%0d", k), MShow | MPhase, 3'b000});
      end else begin
        show_hold_n = 1'b0;
        clock_en    = 1'b1;
        show_time   = (k == 0) ? 3'd0 : 3'($urandom);
        exp_q.push_back('{$sformatf("b2b k=%0d", k), 3'b111,
                          {((k % 4) == 3), (k >= 8), (k >= 4)}});
      end
      step();
      e = exp_q.pop_front();
      obs = {sec_pulse, cook_phase, show};
      n_vec++;
      if ((obs & e.mask) !== (e.val & e.mask)) begin
        n_err++;
        $display("FAIL %s: got %b want %b", e.tag, obs & e.mask, e.val & e.mask);
      end
    end
  endtask

  // Reset mid-operation, then restart from the reset target (SHOW_BASE_SECS).
  task automatic test_reset_mid();
    exp_t e;
    logic [2:0] obs;
    for (int k = -1; k <= 9; k++) begin
      resetn      = (k >= 0);
      show_hold_n = 1'b0;
      clock_en    = 1'b1;
      show_time   = 3'($urandom);
      if (k < 0) begin
        exp_q.push_back('{"reset_mid", 3'b111, 3'b000});
      end else begin
        exp_q.push_back('{$sformatf("post_reset k=%0d", k), MShow | MPhase,
                          {1'b0, (k >= 8), (k >= 4)}});
      end
      step();
      e = exp_q.pop_front();
      obs = {sec_pulse, cook_phase, show};
      n_vec++;
      if ((obs & e.mask) !== (e.val & e.mask)) begin
        n_err++;
        $display("FAIL %s: got %b want %b", e.tag, obs & e.mask, e.val & e.mask);
      end
    end
    resetn = 1'b1;
  endtask

`ifdef STEAK_TIMER_PAUSE_EN
  task automatic test_pause();
    exp_t e;
    logic [2:0] obs;
    for (int k = -2; k <= 24; k++) begin
      clock_en = 1'b0;
      pause    = (k >= 5) && (k <= 9);
      if (k < 0) begin
        show_hold_n = 1'b1;
      end else begin
        show_hold_n = 1'b0;
        show_time   = (k == 0) ? 3'd2 : 3'($urandom);
      end
      exp_q.push_back('{$sformatf("pause k=%0d", k), MShow, {2'b00, (k >= 17)}});
      step();
      e = exp_q.pop_front();
      obs = {sec_pulse, cook_phase, show};
      n_vec++;
      if ((obs & e.mask) !== (e.val & e.mask)) begin
        n_err++;
        $display("FAIL %s: got %b want %b", e.tag, obs & e.mask, e.val & e.mask);
      end
    end
    pause = 1'b0;
  endtask
`endif

  initial begin
    resetn      = 1'b0;
    clock_en    = 1'b0;
    show_hold_n = 1'b1;
    show_time   = 3'd0;
`ifdef STEAK_TIMER_PAUSE_EN
    pause       = 1'b0;
`endif
    #2;
    test_reset();
    test_spawn();
    test_cancel();
    test_cook();
    test_wait();
    test_back_to_back();
    test_reset_mid();
`ifdef STEAK_TIMER_PAUSE_EN
    test_pause();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at time %0t, required done", $time);
    $fatal(1, "timeout");
  end

endmodule
